// File: rtl/ex_div_pkg.sv
// ============================================================================
// ex_div_pkg : shared constants and state encoding for the EX-stage divider
// Revision   : 1.0
// ============================================================================
`default_nettype none

package ex_div_pkg;

    localparam int DIV_WIDTH = 32;

    // Fill bit for the divide-by-zero quotient (replicated to all ones).
    localparam logic DIV_ZERO_FILL = 1'b1;

    typedef logic [1:0] div_state_t;

    localparam div_state_t ST_IDLE = 2'd0;
    localparam div_state_t ST_RUN  = 2'd1;
    localparam div_state_t ST_FIX  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/ex_div_step.sv
// ============================================================================
// ex_div_step : one combinational radix-2 restoring division iteration
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ex_div_step
    import ex_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // shifted < 2*divisor, so bit WIDTH of the difference is a reliable sign.
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_out = diff[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = shifted[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_divider.sv
// ============================================================================
// ex_divider : multi-cycle signed/unsigned restoring divider with busy/done
// Revision   : 1.0
// ============================================================================
`default_nettype none

module ex_divider
    import ex_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Div_Start_EX,
    input  logic             Div_Signed_EX,
    input  logic [WIDTH-1:0] Dividend_EX,
    input  logic [WIDTH-1:0] Divisor_EX,
    output logic [WIDTH-1:0] Quotient_EX,
    output logic [WIDTH-1:0] Remainder_EX,
    output logic             Div_Busy_EX,
    output logic             Div_Done_EX,
    output logic             Div_By_Zero_EX
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_mag;
    logic             neg_quo;
    logic             neg_rem;
    logic             zero_div;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] fixed_quo;
    logic [WIDTH-1:0] fixed_rem;

    always_comb begin
        a_neg     = Div_Signed_EX & Dividend_EX[WIDTH-1];
        b_neg     = Div_Signed_EX & Divisor_EX[WIDTH-1];
        a_mag     = a_neg ? (~Dividend_EX + 1'b1) : Dividend_EX;
        b_mag     = b_neg ? (~Divisor_EX + 1'b1) : Divisor_EX;
        fixed_quo = neg_quo ? (~quo_q + 1'b1) : quo_q;
        fixed_rem = neg_rem ? (~rem_q + 1'b1) : rem_q;
    end

    ex_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_mag),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= ST_IDLE;
            count          <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            dvs_mag        <= '0;
            neg_quo        <= 1'b0;
            neg_rem        <= 1'b0;
            zero_div       <= 1'b0;
            Quotient_EX    <= '0;
            Remainder_EX   <= '0;
            Div_Busy_EX    <= 1'b0;
            Div_Done_EX    <= 1'b0;
            Div_By_Zero_EX <= 1'b0;
        end else begin
            Div_Done_EX <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Div_Start_EX) begin
                        neg_quo     <= a_neg ^ b_neg;
                        neg_rem     <= a_neg;
                        dvs_mag     <= b_mag;
                        count       <= '0;
                        Div_Busy_EX <= 1'b1;
                        // Zero divisor skips RUN; rem_q carries the raw dividend to FIX.
                        if (Divisor_EX == '0) begin
                            zero_div <= 1'b1;
                            rem_q    <= Dividend_EX;
                            quo_q    <= '0;
                            state    <= ST_FIX;
                        end else begin
                            zero_div <= 1'b0;
                            rem_q    <= '0;
                            quo_q    <= a_mag;
                            state    <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    Div_Busy_EX    <= 1'b0;
                    Div_Done_EX    <= 1'b1;
                    Div_By_Zero_EX <= zero_div;
                    if (zero_div) begin
                        Quotient_EX  <= {WIDTH{DIV_ZERO_FILL}};
                        Remainder_EX <= rem_q;
                    end else begin
                        Quotient_EX  <= fixed_quo;
                        Remainder_EX <= fixed_rem;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
